// File: rtl/mul_pkg.sv
// Shared types for the multiplier write-back path: op encodings, queue entry
// and beat-select state.
package mul_pkg;

  localparam int unsigned MUL_RES_W = 64;
  localparam int unsigned WB_W      = 32;
  localparam int unsigned RD_W      = 5;

  typedef enum logic [1:0] {
    OP_LO   = 2'b00,
    OP_HI   = 2'b01,
    OP_BOTH = 2'b10,
    OP_RSVD = 2'b11
  } mul_op_e;

  typedef struct packed {
    logic [MUL_RES_W-1:0] data;
    mul_op_e              op;
    logic [RD_W-1:0]      rd;
  } mul_entry_t;

  typedef enum logic {
    BEAT_FIRST  = 1'b0,
    BEAT_SECOND = 1'b1
  } beat_e;

endpackage

// File: rtl/mul_wb_queue_if.sv
// Bundle of issue-credit, multiplier-result and register-file write-back signals.
interface mul_wb_queue_if;
  import mul_pkg::*;

  logic                 issue_fire;
  logic                 issue_ok;
  logic                 res_valid;
  logic [MUL_RES_W-1:0] res_data;
  logic [1:0]           res_op;
  logic [RD_W-1:0]      res_rd;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [RD_W-1:0]      wb_rd;
  logic [WB_W-1:0]      wb_data;
  logic                 wb_hi;
  logic                 err;

  modport master (
    output issue_fire, res_valid, res_data, res_op, res_rd, wb_ready,
    input  issue_ok, wb_valid, wb_rd, wb_data, wb_hi, err
  );

  modport slave (
    input  issue_fire, res_valid, res_data, res_op, res_rd, wb_ready,
    output issue_ok, wb_valid, wb_rd, wb_data, wb_hi, err
  );
endinterface

// File: rtl/mul_wb_fifo.sv
// Circular FIFO of multiplier result entries; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module mul_wb_fifo
  import mul_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  mul_entry_t             din,
  output mul_entry_t             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  mul_entry_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // Storage is cleared too so the read port never shows X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      mem    <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mul_wb_queue.sv
// Multiplier write-back queue: buffers 64-bit products, splits them into 32-bit
// register-file beats and hands out issue credits so the queue never overflows.
module mul_wb_queue
  import mul_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INFL_W = 3
) (
  input  logic          mul_clk,
  input  logic          reset,
  mul_wb_queue_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = ((CNT_W > INFL_W) ? CNT_W : INFL_W) + 1;

  mul_entry_t        head;
  mul_entry_t        din;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              xfer;
  logic [INFL_W-1:0] inflight;
  logic [SUM_W-1:0]  credit_sum;
  logic              issue_ok_c;
  logic              err_q;
  logic              set_err;
  beat_e             beat_q;
  beat_e             beat_d;
  logic [WB_W-1:0]   wb_data_c;
  logic [RD_W-1:0]   wb_rd_c;
  logic              wb_hi_c;

  assign din = '{data: bus.res_data, op: mul_op_e'(bus.res_op), rd: bus.res_rd};

  mul_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (mul_clk),
    .rst   (reset),
    .push  (bus.res_valid),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Credits: queued entries plus results still inside the multiplier.
  assign credit_sum = SUM_W'(count) + SUM_W'(inflight);
  assign issue_ok_c = (credit_sum < SUM_W'(DEPTH));

  assign set_err = (bus.issue_fire && !issue_ok_c)
                || (bus.res_valid && (inflight == '0))
                || (bus.res_valid && full && !pop);

  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_q | set_err;
      if (bus.issue_fire && !bus.res_valid) begin
        if (inflight != INFL_W'(DEPTH)) inflight <= inflight + INFL_W'(1);
      end else if (!bus.issue_fire && bus.res_valid) begin
        if (inflight != '0) inflight <= inflight - INFL_W'(1);
      end
    end
  end

  // Beat-select state register.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) beat_q <= BEAT_FIRST;
    else       beat_q <= beat_d;
  end

  assign xfer = !empty && bus.wb_ready;

  // Beat sequencing and write-back word/destination selection.
  always_comb begin
    beat_d    = beat_q;
    pop       = 1'b0;
    wb_data_c = head.data[WB_W-1:0];
    wb_rd_c   = head.rd;
    wb_hi_c   = 1'b0;
    case (beat_q)
      BEAT_FIRST: begin
        if (head.op == OP_HI) begin
          wb_data_c = head.data[MUL_RES_W-1:WB_W];
          wb_hi_c   = 1'b1;
        end
        if (xfer) begin
          if (head.op == OP_BOTH) beat_d = BEAT_SECOND;
          else                    pop    = 1'b1;
        end
      end
      BEAT_SECOND: begin
        wb_data_c = head.data[MUL_RES_W-1:WB_W];
        wb_rd_c   = head.rd + RD_W'(1);
        wb_hi_c   = 1'b1;
        if (xfer) begin
          pop    = 1'b1;
          beat_d = BEAT_FIRST;
        end
      end
      default: beat_d = BEAT_FIRST;
    endcase
  end

  assign bus.issue_ok = issue_ok_c;
  assign bus.wb_valid = !empty;
  assign bus.wb_data  = wb_data_c;
  assign bus.wb_rd    = wb_rd_c;
  assign bus.wb_hi    = wb_hi_c;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mul_wb_queue.sv
// Bench for mul_wb_queue: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mul_wb_queue;
  import mul_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic mul_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 mul_clk = ~mul_clk;

  mul_wb_queue_if bus ();

  mul_wb_queue #(.DEPTH(DEPTH), .INFL_W(3)) dut (
    .mul_clk (mul_clk),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  op;
    logic [4:0]  rd;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_beat = 0;
  int     m_infl = 0;
  bit     m_err  = 1'b0;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [4:0] rd);
    return {32'hA000_0000 | 32'(rd), 32'hB000_0000 | 32'(rd)};
  endfunction

  // Reference model: a plain queue of results plus beat index and credit count.
  always @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_beat = 0;
      m_infl = 0;
      m_err  = 1'b0;
    end else begin
      int sz;
      bit popped;
      bit ok;
      m_ent_t e;
      sz     = mq.size();
      popped = 1'b0;
      ok     = (sz + m_infl) < DEPTH;
      if (sz != 0 && bus.wb_ready) begin
        if (mq[0].op == 2'b10 && m_beat == 0) m_beat = 1;
        else begin
          m_beat = 0;
          popped = 1'b1;
          void'(mq.pop_front());
        end
      end
      if (bus.res_valid) begin
        e.data = bus.res_data;
        e.op   = bus.res_op;
        e.rd   = bus.res_rd;
        if (sz < DEPTH || popped) mq.push_back(e);
        else m_err = 1'b1;
        if (m_infl == 0) m_err = 1'b1;
      end
      if (bus.issue_fire && !ok) m_err = 1'b1;
      if (bus.issue_fire && !bus.res_valid) begin
        if (m_infl < DEPTH) m_infl++;
      end else if (!bus.issue_fire && bus.res_valid && m_infl > 0) begin
        m_infl--;
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge mul_clk) begin
    if (!reset) begin
      logic [31:0] exp_data;
      logic [4:0]  exp_rd;
      logic        exp_hi;
      check("m_issue_ok", bus.issue_ok, 64'((mq.size() + m_infl) < DEPTH));
      check("m_wb_valid", bus.wb_valid, 64'(mq.size() != 0));
      check("m_err", bus.err, 64'(m_err));
      if (mq.size() != 0) begin
        if (mq[0].op == 2'b10) begin
          exp_hi   = (m_beat == 1);
          exp_data = exp_hi ? mq[0].data[63:32] : mq[0].data[31:0];
          exp_rd   = exp_hi ? 5'(mq[0].rd + 5'd1) : mq[0].rd;
        end else begin
          exp_hi   = (mq[0].op == 2'b01);
          exp_data = exp_hi ? mq[0].data[63:32] : mq[0].data[31:0];
          exp_rd   = mq[0].rd;
        end
        check("m_wb_rd", bus.wb_rd, 64'(exp_rd));
        check("m_wb_data", bus.wb_data, 64'(exp_data));
        check("m_wb_hi", bus.wb_hi, 64'(exp_hi));
      end
    end
  end

  task automatic cyc(input bit fire, input bit rv, input logic [63:0] d,
                     input logic [1:0] op, input logic [4:0] rd, input bit rdy);
    @(posedge mul_clk);
    #1;
    bus.issue_fire = fire;
    bus.res_valid  = rv;
    bus.res_data   = d;
    bus.res_op     = op;
    bus.res_rd     = rd;
    bus.wb_ready   = rdy;
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 1'b0, 64'h0, 2'b00, 5'd0, rdy);
  endtask

  task automatic beat_chk(input string name, input logic [4:0] rd, input logic [31:0] d, input bit hi);
    @(negedge mul_clk);
    check({name, "_valid"}, bus.wb_valid, 64'd1);
    check({name, "_rd"}, bus.wb_rd, 64'(rd));
    check({name, "_data"}, bus.wb_data, 64'(d));
    check({name, "_hi"}, bus.wb_hi, 64'(hi));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.issue_fire = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_data   = '0;
    bus.res_op     = '0;
    bus.res_rd     = '0;
    bus.wb_ready   = 1'b0;

    // Reset values
    repeat (2) @(posedge mul_clk);
    #1;
    check("rst_wb_valid", bus.wb_valid, 64'd0);
    check("rst_wb_rd", bus.wb_rd, 64'd0);
    check("rst_wb_data", bus.wb_data, 64'd0);
    check("rst_wb_hi", bus.wb_hi, 64'd0);
    check("rst_err", bus.err, 64'd0);
    check("rst_issue_ok", bus.issue_ok, 64'd1);
    reset = 1'b0;

    // LO op
    cyc(1'b1, 1'b0, 64'h0, 2'b00, 5'd0, 1'b1);
    cyc(1'b0, 1'b1, 64'h0000_0001_FFFF_FFFE, 2'b00, 5'd5, 1'b1);
    idle(1'b1);
    beat_chk("lo", 5'd5, 32'hFFFF_FFFE, 1'b0);
    idle(1'b1);
    @(negedge mul_clk);
    check("lo_after_valid", bus.wb_valid, 64'd0);
    check("lo_after_issue_ok", bus.issue_ok, 64'd1);
    check("lo_after_err", bus.err, 64'd0);

    // BOTH op with a three-cycle stall, rd=31 wraps to 0 on the high beat
    cyc(1'b1, 1'b0, 64'h0, 2'b00, 5'd0, 1'b0);
    cyc(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 2'b10, 5'd31, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      beat_chk("both_stall", 5'd31, 32'h9ABC_DEF0, 1'b0);
    end
    idle(1'b1);
    beat_chk("both_b0", 5'd31, 32'h9ABC_DEF0, 1'b0);
    idle(1'b1);
    beat_chk("both_b1", 5'd0, 32'h1234_5678, 1'b1);
    idle(1'b1);
    @(negedge mul_clk);
    check("both_done_valid", bus.wb_valid, 64'd0);

    // Credit limit: four issues exhaust the credits until the first pop
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 64'h0, 2'b00, 5'd0, 1'b0);
    @(negedge mul_clk);
    check("cred_before_4th", bus.issue_ok, 64'd1);
    begin
      logic [1:0] ops [4];
      ops[0] = 2'b00; ops[1] = 2'b01; ops[2] = 2'b10; ops[3] = 2'b00;
      for (int i = 0; i < 4; i++) begin
        cyc(1'b0, 1'b1, mk(5'(i + 1)), ops[i], 5'(i + 1), 1'b0);
        @(negedge mul_clk);
        check("cred_full_issue_ok", bus.issue_ok, 64'd0);
      end
    end
    idle(1'b0);
    beat_chk("cred_head", 5'd1, 32'hB000_0001, 1'b0);
    check("cred_err", bus.err, 64'd0);
    idle(1'b1);
    @(negedge mul_clk);
    check("cred_pre_pop", bus.issue_ok, 64'd0);
    idle(1'b0);
    @(negedge mul_clk);
    check("cred_post_pop", bus.issue_ok, 64'd1);
    check("cred_err2", bus.err, 64'd0);

    // Refill to full (head HI rd2), then push and pop together while full
    cyc(1'b1, 1'b0, 64'h0, 2'b00, 5'd0, 1'b0);
    cyc(1'b0, 1'b1, mk(5'd6), 2'b00, 5'd6, 1'b0);
    cyc(1'b1, 1'b0, 64'h0, 2'b00, 5'd0, 1'b0);
    @(negedge mul_clk);
    check("ovr_issue_ok", bus.issue_ok, 64'd0);
    cyc(1'b0, 1'b1, mk(5'd7), 2'b00, 5'd7, 1'b1);
    beat_chk("pp_head", 5'd2, 32'hA000_0002, 1'b1);
    check("pp_err", bus.err, 64'd1);
    idle(1'b1);
    beat_chk("pp_d0", 5'd3, 32'hB000_0003, 1'b0);
    idle(1'b1);
    beat_chk("pp_d1", 5'd4, 32'hA000_0003, 1'b1);
    idle(1'b1);
    beat_chk("pp_d2", 5'd4, 32'hB000_0004, 1'b0);
    idle(1'b1);
    beat_chk("pp_d3", 5'd6, 32'hB000_0006, 1'b0);
    idle(1'b1);
    beat_chk("pp_d4", 5'd7, 32'hB000_0007, 1'b0);
    idle(1'b1);
    @(negedge mul_clk);
    check("pp_drained", bus.wb_valid, 64'd0);

    // Clear the sticky error
    @(posedge mul_clk);
    #1 reset = 1'b1;
    @(posedge mul_clk);
    #1 reset = 1'b0;
    @(negedge mul_clk);
    check("rst2_err", bus.err, 64'd0);

    // Pointer wrap: ten LO results streamed back to back
    for (int i = 0; i < 12; i++) begin
      cyc(i < 10, (i >= 1) && (i <= 10), mk(5'(i - 1)), 2'b00, 5'(i - 1), 1'b1);
      if (i >= 2) begin
        @(negedge mul_clk);
        check("wrap_valid", bus.wb_valid, 64'd1);
        check("wrap_rd", bus.wb_rd, 64'(i - 2));
      end
    end
    idle(1'b1);
    @(negedge mul_clk);
    check("wrap_done_valid", bus.wb_valid, 64'd0);
    check("wrap_err", bus.err, 64'd0);

    // Result without an issue sets err; async reset mid-BOTH clears everything
    cyc(1'b0, 1'b1, mk(5'd8), 2'b00, 5'd8, 1'b0);
    @(negedge mul_clk);
    check("err_pre", bus.err, 64'd0);
    idle(1'b0);
    @(negedge mul_clk);
    check("err_set", bus.err, 64'd1);
    cyc(1'b1, 1'b0, 64'h0, 2'b00, 5'd0, 1'b0);
    cyc(1'b0, 1'b1, mk(5'd9), 2'b10, 5'd9, 1'b0);
    idle(1'b1);
    beat_chk("err_h8", 5'd8, 32'hB000_0008, 1'b0);
    idle(1'b1);
    beat_chk("err_h9", 5'd9, 32'hB000_0009, 1'b0);
    idle(1'b0);
    beat_chk("err_h9b1", 5'd10, 32'hA000_0009, 1'b1);
    check("err_sticky", bus.err, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_err", bus.err, 64'd0);
    check("arst_valid", bus.wb_valid, 64'd0);
    check("arst_issue_ok", bus.issue_ok, 64'd1);
    check("arst_hi", bus.wb_hi, 64'd0);
    check("arst_data", bus.wb_data, 64'd0);
    @(posedge mul_clk);
    #1 reset = 1'b0;
    idle(1'b1);
    @(negedge mul_clk);
    check("post_rst_valid", bus.wb_valid, 64'd0);
    check("post_rst_err", bus.err, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_wb_queue.md
Name: mul_wb_queue

Overview:
- Downstream of the pipelined multiplier; collects each 64-bit product as it emerges and presents it to the register-file write port as 32-bit write-back beats, with valid/ready.
- The multiplier has no output back-pressure. This block therefore also issues credits: it counts operations in flight in the multiplier so that no result can ever arrive at a full queue.
- Per-entry op selects low word, high word, or both words (two beats).

Parameters:
- DEPTH, 4, result queue entries; power of two, at least 2.
- INFL_W, 3, width of in-flight counter; must hold DEPTH.

Ports:
- mul_clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_fire  in  1  an operation entered the multiplier this cycle (in_valid && in_ready at the multiplier).
- issue_ok  out  1  upstream may fire an operation this cycle.
- res_valid  in  1  multiplier out_valid.
- res_data  in  64  multiplier result.
- res_op  in  2  op for this result: 00 LO, 01 HI, 10 BOTH, 11 reserved (treated as LO).
- res_rd  in  5  destination register.
- wb_valid  out  1  write-back beat available.
- wb_ready  in  1  register-file port accepts the beat.
- wb_rd  out  5  write destination.
- wb_data  out  32  write data.
- wb_hi  out  1  1 when the beat carries res_data[63:32].
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset, asynchronous and active-high:
  - Pointers, count, inflight, beat select and err all return to 0.
  - Outputs: wb_valid=0, wb_rd=0, wb_data=0, wb_hi=0, err=0.
  - issue_ok=1, because count=0 and inflight=0.
  - Reset in the middle of a two-beat entry abandons it; the queue contents are discarded.
- Storage: circular FIFO of {data[63:0], op[1:0], rd[4:0]}.
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is 0..DEPTH.
- Push:
  - Occurs on res_valid. The entry is written at the clock edge.
  - wb_valid can rise no earlier than the next cycle. There is no same-cycle bypass.
- issue_ok = (count + inflight) < DEPTH. It is a combinational function of registered state only and does not depend on issue_fire.
- inflight update:
  - +1 on issue_fire; -1 on res_valid; unchanged when both occur in the same cycle.
  - res_valid with inflight=0: inflight stays 0 and err is set.
  - issue_fire while issue_ok=0: inflight still increments, saturating at DEPTH, and err is set.
- Push while full with no pop in the same cycle: the entry is dropped, err is set, and pointers and count do not change.
- Push and pop in the same cycle while full: both take effect and count is unchanged.
- Beat logic:
  - wb_valid = (count != 0).
  - Head op LO: single beat; wb_data = data[31:0], wb_hi = 0, wb_rd = rd.
  - Head op HI: single beat; wb_data = data[63:32], wb_hi = 1, wb_rd = rd.
  - Head op BOTH, beat 0: low word, wb_rd = rd, wb_hi = 0.
  - Head op BOTH, beat 1: high word, wb_rd = (rd + 1) mod 32, so rd=31 wraps to 0; wb_hi = 1.
  - A beat transfers on wb_valid && wb_ready.
  - The entry pops on the final beat of its op. beat_sel returns to 0 on pop.
- Beat-select states:
  - FIRST: beat_sel=0. On a transfer of a BOTH entry, go to SECOND. On a transfer of any other op, pop and stay in FIRST.
  - SECOND: beat_sel=1. On a transfer, pop and return to FIRST.
  - With wb_ready=0, the state and outputs hold stable.
- Outputs while wb_valid=0: wb_data, wb_rd and wb_hi are driven from the entry at the read pointer. They are don't-care but must not be X after reset.
- err is cleared only by reset.

Decomposition:
- Shared package (mul_pkg) holds:
  - Op encodings: OP_LO=2'b00, OP_HI=2'b01, OP_BOTH=2'b10.
  - The queue entry struct {data, op, rd}.
  - MUL_RES_W=64, WB_W=32, RD_W=5.
- Sub-module mul_wb_fifo: generic DEPTH-entry FIFO with push/pop/full/empty/count. The beat logic and credit logic stay in mul_wb_queue.

Test Plan:
- LO op:
  - Stimulus: issue_fire one cycle, then res_valid with res_data=64'h0000_0001_FFFF_FFFE, op=LO, rd=5, wb_ready=1.
  - Response: one beat the next cycle with wb_rd=5, wb_data=32'hFFFF_FFFE, wb_hi=0. Afterwards count=0, inflight=0, err=0.
- BOTH op with stall:
  - Stimulus: res_data=64'h1234_5678_9ABC_DEF0, op=BOTH, rd=31; wb_ready=0 for 3 cycles, then 1.
  - Response: beat 0 (rd=31, 32'h9ABC_DEF0, hi=0) holds stable during the stall. Beat 1 follows with rd=0, 32'h1234_5678, hi=1. Then wb_valid=0.
- Credit limit:
  - Stimulus: DEPTH=4, wb_ready=0; fire 4 issues and 4 results.
  - Response: issue_ok falls after the 4th issue and rises one cycle after the first pop. err stays 0.
- Simultaneous push and pop:
  - Stimulus: queue full, wb_ready=1, head op HI, res_valid in the same cycle as the pop.
  - Response: count stays 4, there is no drop, and the entry order is preserved.
- Pointer wrap-around:
  - Stimulus: 10 LO results with rd=0..9 streamed back-to-back, wb_ready=1.
  - Response: outputs appear in order rd 0..9 with no loss.
- Error and reset:
  - Stimulus: res_valid with inflight=0.
  - Response: err=1 and stays 1. Asserting reset mid-BOTH clears err, wb_valid and issue_ok state (issue_ok=1) asynchronously.
